// File: rtl/bip_pkg.sv
// rtl/bip_pkg.sv - shared opcodes, FSM states and datapath select encodings for the BIP control unit
package bip_pkg;

  localparam int NBITS_I   = 16;
  localparam int NBITS_OPC = 5;
  localparam int NBITS_O   = 11;
  localparam int NBITS_PC  = 11;
  localparam int NBITS_CNT = 32;

  localparam logic [NBITS_OPC-1:0] OPC_HLT  = 5'b00000;
  localparam logic [NBITS_OPC-1:0] OPC_STO  = 5'b00001;
  localparam logic [NBITS_OPC-1:0] OPC_LD   = 5'b00010;
  localparam logic [NBITS_OPC-1:0] OPC_LDI  = 5'b00011;
  localparam logic [NBITS_OPC-1:0] OPC_ADD  = 5'b00100;
  localparam logic [NBITS_OPC-1:0] OPC_ADDI = 5'b00101;
  localparam logic [NBITS_OPC-1:0] OPC_SUB  = 5'b00110;
  localparam logic [NBITS_OPC-1:0] OPC_SUBI = 5'b00111;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_HALT   = 3'd4
  } state_e;

  localparam logic [1:0] SELA_MEM = 2'd0;
  localparam logic [1:0] SELA_IMM = 2'd1;
  localparam logic [1:0] SELA_ALU = 2'd2;

  localparam logic SELB_MEM = 1'b0;
  localparam logic SELB_IMM = 1'b1;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/bip_instruction_decoder.sv
// rtl/bip_instruction_decoder.sv - combinational opcode decode into datapath controls and memory strobes
//
// Ports:
//   opcode_i     opcode to decode (incoming instruction in DECODE, IR in EXECUTE)
//   decode_en_i  FSM is in DECODE; enables the data-memory read strobe
//   exec_en_i    FSM is in EXECUTE; enables write strobes and halt detection
//   sel_a_o      accumulator source select (ungated)
//   sel_b_o      ALU B source select (ungated)
//   op_o         ALU operation (ungated)
//   wr_acc_o     accumulator write strobe
//   wr_ram_o     data memory write strobe
//   rd_ram_o     data memory read strobe
//   is_halt_o    HLT seen in EXECUTE
module bip_instruction_decoder
  import bip_pkg::*;
(
  input  logic [NBITS_OPC-1:0] opcode_i,
  input  logic                 decode_en_i,
  input  logic                 exec_en_i,
  output logic [1:0]           sel_a_o,
  output logic                 sel_b_o,
  output logic                 op_o,
  output logic                 wr_acc_o,
  output logic                 wr_ram_o,
  output logic                 rd_ram_o,
  output logic                 is_halt_o
);

  logic acc_write;
  logic ram_write;
  logic ram_read;
  logic halt;

  always_comb begin
    sel_a_o   = SELA_MEM;
    sel_b_o   = SELB_MEM;
    op_o      = OP_ADD;
    acc_write = 1'b0;
    ram_write = 1'b0;
    ram_read  = 1'b0;
    halt      = 1'b0;
    unique case (opcode_i)
      OPC_HLT:  halt = 1'b1;
      OPC_STO:  ram_write = 1'b1;
      OPC_LD: begin
        sel_a_o   = SELA_MEM;
        acc_write = 1'b1;
        ram_read  = 1'b1;
      end
      OPC_LDI: begin
        sel_a_o   = SELA_IMM;
        acc_write = 1'b1;
      end
      OPC_ADD: begin
        sel_a_o   = SELA_ALU;
        sel_b_o   = SELB_MEM;
        op_o      = OP_ADD;
        acc_write = 1'b1;
        ram_read  = 1'b1;
      end
      OPC_ADDI: begin
        sel_a_o   = SELA_ALU;
        sel_b_o   = SELB_IMM;
        op_o      = OP_ADD;
        acc_write = 1'b1;
      end
      OPC_SUB: begin
        sel_a_o   = SELA_ALU;
        sel_b_o   = SELB_MEM;
        op_o      = OP_SUB;
        acc_write = 1'b1;
        ram_read  = 1'b1;
      end
      OPC_SUBI: begin
        sel_a_o   = SELA_ALU;
        sel_b_o   = SELB_IMM;
        op_o      = OP_SUB;
        acc_write = 1'b1;
      end
      default: ;  // unassigned opcodes behave as NOP
    endcase
  end

  // Memory reads are issued a cycle early so the data lands for EXECUTE.
  assign rd_ram_o  = decode_en_i & ram_read;
  assign wr_acc_o  = exec_en_i & acc_write;
  assign wr_ram_o  = exec_en_i & ram_write;
  assign is_halt_o = exec_en_i & halt;

endmodule

// File: rtl/bip_control_unit.sv
// rtl/bip_control_unit.sv - 3-cycle fetch/decode/execute sequencer for the BIP accumulator CPU
//
// Optional feature macro: BIP_CYCLE_COUNTER_EN (adds o_CycleCount busy-cycle counter).
//
// Ports:
//   i_clock        clock, rising edge
//   i_reset        asynchronous active-low reset
//   i_start        starts execution from IDLE
//   i_Instruction  instruction memory read data, valid 1 cycle after o_RdInstr
//   o_InstrAddr    instruction address (PC)
//   o_RdInstr      instruction memory read strobe
//   o_DataAddr     data memory address
//   o_RdRam        data memory read strobe (DECODE)
//   o_WrRam        data memory write strobe (EXECUTE of STO)
//   o_Operand      immediate operand to datapath
//   o_SelA         accumulator source select
//   o_SelB         ALU B source select
//   o_WrAcc        accumulator write enable
//   o_Op           ALU add/subtract
//   o_Busy         executing a program
//   o_Halt         halted
//   o_CycleCount   busy-cycle count (only with BIP_CYCLE_COUNTER_EN)
module bip_control_unit
  import bip_pkg::*;
(
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_start,
  input  logic [NBITS_I-1:0]   i_Instruction,
  output logic [NBITS_PC-1:0]  o_InstrAddr,
  output logic                 o_RdInstr,
  output logic [NBITS_O-1:0]   o_DataAddr,
  output logic                 o_RdRam,
  output logic                 o_WrRam,
  output logic [NBITS_O-1:0]   o_Operand,
  output logic [1:0]           o_SelA,
  output logic                 o_SelB,
  output logic                 o_WrAcc,
  output logic                 o_Op,
`ifdef BIP_CYCLE_COUNTER_EN
  output logic [NBITS_CNT-1:0] o_CycleCount,
`endif
  output logic                 o_Busy,
  output logic                 o_Halt
);

  state_e               state_q, state_d;
  logic [NBITS_PC-1:0]  pc_q, pc_d;
  logic [NBITS_I-1:0]   ir_q, ir_d;
  logic [1:0]           sel_a_q;
  logic                 sel_b_q;
  logic                 op_q;

  logic                 in_decode;
  logic                 in_exec;
  logic [NBITS_OPC-1:0] dec_opcode;
  logic [1:0]           dec_sel_a;
  logic                 dec_sel_b;
  logic                 dec_op;
  logic                 dec_wr_acc;
  logic                 dec_wr_ram;
  logic                 dec_rd_ram;
  logic                 dec_halt;

  assign in_decode = (state_q == ST_DECODE);
  assign in_exec   = (state_q == ST_EXEC);

  // In DECODE the IR is not loaded yet, so decode straight from the memory bus.
  assign dec_opcode = in_decode ? i_Instruction[NBITS_I-1 -: NBITS_OPC]
                                : ir_q[NBITS_I-1 -: NBITS_OPC];

  bip_instruction_decoder u_decoder (
    .opcode_i    (dec_opcode),
    .decode_en_i (in_decode),
    .exec_en_i   (in_exec),
    .sel_a_o     (dec_sel_a),
    .sel_b_o     (dec_sel_b),
    .op_o        (dec_op),
    .wr_acc_o    (dec_wr_acc),
    .wr_ram_o    (dec_wr_ram),
    .rd_ram_o    (dec_rd_ram),
    .is_halt_o   (dec_halt)
  );

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
      sel_a_q <= SELA_MEM;
      sel_b_q <= SELB_MEM;
      op_q    <= OP_ADD;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      // Selects keep the last accumulator-writing decode between instructions.
      if (dec_wr_acc) begin
        sel_a_q <= dec_sel_a;
        sel_b_q <= dec_sel_b;
        op_q    <= dec_op;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    unique case (state_q)
      ST_IDLE:   if (i_start) state_d = ST_FETCH;
      ST_FETCH:  state_d = ST_DECODE;
      ST_DECODE: begin
        ir_d    = i_Instruction;
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        if (dec_halt) begin
          state_d = ST_HALT;
        end else begin
          pc_d    = pc_q + {{(NBITS_PC-1){1'b0}}, 1'b1};
          state_d = ST_FETCH;
        end
      end
      ST_HALT:   state_d = ST_HALT;
      default:   state_d = ST_IDLE;
    endcase
  end

  assign o_InstrAddr = pc_q;
  assign o_RdInstr   = (state_q == ST_FETCH);
  assign o_DataAddr  = in_decode ? i_Instruction[NBITS_O-1:0] : ir_q[NBITS_O-1:0];
  assign o_Operand   = ir_q[NBITS_O-1:0];
  assign o_RdRam     = dec_rd_ram;
  assign o_WrRam     = dec_wr_ram;
  assign o_WrAcc     = dec_wr_acc;
  assign o_SelA      = in_exec ? dec_sel_a : sel_a_q;
  assign o_SelB      = in_exec ? dec_sel_b : sel_b_q;
  assign o_Op        = in_exec ? dec_op    : op_q;
  assign o_Busy      = (state_q == ST_FETCH) || in_decode || in_exec;
  assign o_Halt      = (state_q == ST_HALT);

`ifdef BIP_CYCLE_COUNTER_EN
  logic [NBITS_CNT-1:0] cnt_q;

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      cnt_q <= '0;
    end else if ((state_q == ST_IDLE) && i_start) begin
      cnt_q <= '0;
    end else if (o_Busy && (cnt_q != {NBITS_CNT{1'b1}})) begin
      cnt_q <= cnt_q + {{(NBITS_CNT-1){1'b0}}, 1'b1};
    end
  end

  assign o_CycleCount = cnt_q;
`endif

endmodule

// File: tb/tb_bip_control_unit.sv
// tb/tb_bip_control_unit.sv - directed self-checking bench for bip_control_unit
module tb_bip_control_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] instr;
  logic [10:0] instr_addr;
  logic        rd_instr;
  logic [10:0] data_addr;
  logic        rd_ram;
  logic        wr_ram;
  logic [10:0] operand;
  logic [1:0]  sel_a;
  logic        sel_b;
  logic        wr_acc;
  logic        op;
  logic        busy;
  logic        halt;
`ifdef BIP_CYCLE_COUNTER_EN
  logic [31:0] cycle_count;
`endif

  logic [15:0] imem [0:2047];

  int errors = 0;
  int checks = 0;

  bip_control_unit dut (
    .i_clock       (clk),
    .i_reset       (rst_n),
    .i_start       (start),
    .i_Instruction (instr),
    .o_InstrAddr   (instr_addr),
    .o_RdInstr     (rd_instr),
    .o_DataAddr    (data_addr),
    .o_RdRam       (rd_ram),
    .o_WrRam       (wr_ram),
    .o_Operand     (operand),
    .o_SelA        (sel_a),
    .o_SelB        (sel_b),
    .o_WrAcc       (wr_acc),
    .o_Op          (op),
`ifdef BIP_CYCLE_COUNTER_EN
    .o_CycleCount  (cycle_count),
`endif
    .o_Busy        (busy),
    .o_Halt        (halt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous instruction memory: data valid the cycle after the read strobe.
  always @(posedge clk) begin
    if (rd_instr) instr <= imem[instr_addr];
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_imem(input logic [15:0] fill);
    for (int i = 0; i < 2048; i++) imem[i] = fill;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    start = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  // Raises i_start in IDLE (cycle 0) and advances into cycle 1.
  task automatic kick();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    int n;
    bit found;
    rst_n = 1'b0;
    start = 1'b0;
    instr = 16'h0000;
    clear_imem(16'h0000);

    // Reset state
    step();
    chk("rst_busy",   {31'd0, busy},     32'd0);
    chk("rst_halt",   {31'd0, halt},     32'd0);
    chk("rst_pc",     {21'd0, instr_addr}, 32'd0);
    chk("rst_rdinstr",{31'd0, rd_instr}, 32'd0);
    chk("rst_wracc",  {31'd0, wr_acc},   32'd0);
    chk("rst_daddr",  {21'd0, data_addr}, 32'd0);
    rst_n = 1'b1;
    step();

    // Reset asserted in the middle of EXECUTE of ADDI 7
    imem[0] = 16'h2807;
    kick();
    step();
    step();
    chk("addi_exec_wracc", {31'd0, wr_acc}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_wracc", {31'd0, wr_acc}, 32'd0);
    chk("midrst_pc",    {21'd0, instr_addr}, 32'd0);
    chk("midrst_busy",  {31'd0, busy}, 32'd0);
    chk("midrst_sela",  {30'd0, sel_a}, 32'd0);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) step();
    chk("postrst_rdinstr", {31'd0, rd_instr}, 32'd0);
    chk("postrst_busy",    {31'd0, busy}, 32'd0);

    // LDI 5; ADDI 3; STO 0x010; HLT
    clear_imem(16'h0000);
    imem[0] = 16'h1805;
    imem[1] = 16'h2803;
    imem[2] = 16'h0810;
    imem[3] = 16'h0000;
    kick();                                                // cycle 1
    chk("p1_c1_rdinstr", {31'd0, rd_instr}, 32'd1);
    chk("p1_c1_addr",    {21'd0, instr_addr}, 32'd0);
    chk("p1_c1_busy",    {31'd0, busy}, 32'd1);
    step();                                                // cycle 2
    chk("p1_c2_rdram",   {31'd0, rd_ram}, 32'd0);
    step();                                                // cycle 3
    chk("p1_c3_wracc",   {31'd0, wr_acc}, 32'd1);
    chk("p1_c3_sela",    {30'd0, sel_a}, 32'd1);
    chk("p1_c3_operand", {21'd0, operand}, 32'd5);
    step();                                                // cycle 4
    chk("p1_c4_wracc",   {31'd0, wr_acc}, 32'd0);
    chk("p1_c4_addr",    {21'd0, instr_addr}, 32'd1);
    step(); step();                                        // cycle 6
    chk("p1_c6_wracc",   {31'd0, wr_acc}, 32'd1);
    chk("p1_c6_sela",    {30'd0, sel_a}, 32'd2);
    chk("p1_c6_selb",    {31'd0, sel_b}, 32'd1);
    chk("p1_c6_op",      {31'd0, op}, 32'd0);
    step(); step(); step();                                // cycle 9
    chk("p1_c9_wrram",   {31'd0, wr_ram}, 32'd1);
    chk("p1_c9_daddr",   {21'd0, data_addr}, 32'h010);
    chk("p1_c9_wracc",   {31'd0, wr_acc}, 32'd0);
    step(); step(); step();                                // cycle 12
    chk("p1_c12_halt",   {31'd0, halt}, 32'd0);
    chk("p1_c12_strobe", {30'd0, wr_acc, wr_ram}, 32'd0);
    step();                                                // cycle 13
    chk("p1_c13_halt",   {31'd0, halt}, 32'd1);
    chk("p1_c13_busy",   {31'd0, busy}, 32'd0);
    chk("p1_c13_pc",     {21'd0, instr_addr}, 32'd3);
    start = 1'b1;
    step(); step(); step();
    start = 1'b0;
    chk("p1_start_ignored_halt", {31'd0, halt}, 32'd1);
    chk("p1_start_ignored_pc",   {21'd0, instr_addr}, 32'd3);

    // LD 0x004; SUB 0x005
    do_reset();
    clear_imem(16'h0000);
    imem[0] = 16'h1004;
    imem[1] = 16'h3005;
    kick();
    step();                                                // cycle 2
    chk("p2_c2_rdram",  {31'd0, rd_ram}, 32'd1);
    chk("p2_c2_daddr",  {21'd0, data_addr}, 32'h004);
    step();                                                // cycle 3
    chk("p2_c3_rdram",  {31'd0, rd_ram}, 32'd0);
    chk("p2_c3_wracc",  {31'd0, wr_acc}, 32'd1);
    chk("p2_c3_sela",   {30'd0, sel_a}, 32'd0);
    step(); step();                                        // cycle 5
    chk("p2_c5_rdram",  {31'd0, rd_ram}, 32'd1);
    chk("p2_c5_daddr",  {21'd0, data_addr}, 32'h005);
    step();                                                // cycle 6
    chk("p2_c6_wracc",  {31'd0, wr_acc}, 32'd1);
    chk("p2_c6_sela",   {30'd0, sel_a}, 32'd2);
    chk("p2_c6_selb",   {31'd0, sel_b}, 32'd0);
    chk("p2_c6_op",     {31'd0, op}, 32'd1);

    // Illegal opcode 11111 behaves as NOP
    do_reset();
    clear_imem(16'h0000);
    imem[0] = 16'hF800;
    kick();
    step();                                                // cycle 2
    chk("p3_c2_rdram",  {31'd0, rd_ram}, 32'd0);
    step();                                                // cycle 3
    chk("p3_c3_strobes", {29'd0, wr_acc, wr_ram, rd_ram}, 32'd0);
    chk("p3_c3_halt",   {31'd0, halt}, 32'd0);
    step();                                                // cycle 4
    chk("p3_c4_rdinstr", {31'd0, rd_instr}, 32'd1);
    chk("p3_c4_addr",   {21'd0, instr_addr}, 32'd1);

    // PC wrap: NOPs at every address until PC 2047 is fetched, then HLT at 0
    do_reset();
    clear_imem(16'h4000);
    kick();
    found = 1'b0;
    for (n = 0; n < 7000 && !found; n++) begin
      if (rd_instr && instr_addr == 11'd2047) found = 1'b1;
      else step();
    end
    chk("wrap_reached_2047", {31'd0, found}, 32'd1);
    imem[0] = 16'h0000;
    found = 1'b0;
    for (n = 0; n < 20 && !found; n++) begin
      step();
      if (halt) found = 1'b1;
    end
    chk("wrap_halted", {31'd0, found}, 32'd1);
    chk("wrap_pc0",    {21'd0, instr_addr}, 32'd0);

`ifdef BIP_CYCLE_COUNTER_EN
    // LDI 1; HLT -> six busy cycles
    do_reset();
    clear_imem(16'h0000);
    imem[0] = 16'h1801;
    kick();
    for (int i = 0; i < 6; i++) step();                    // cycle 7
    chk("cnt_halt",  {31'd0, halt}, 32'd1);
    chk("cnt_value", cycle_count, 32'd6);
    for (int i = 0; i < 10; i++) step();
    chk("cnt_frozen", cycle_count, 32'd6);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
